// File: rtl/mul_err_pkg.sv
// Shared types and helpers for the multiplier error-sweep controller.
// Optional worst-pair capture is enabled with MUL_ERR_WORST_CAPTURE_EN.
package mul_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Widest accumulator the saturating adder supports.
    localparam int SAT_MAX_W = 128;

    function automatic int cnt_width(input int w);
        return 2 * w + 1;
    endfunction

    // Clamps the sum to all-ones at width w instead of wrapping.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] acc,
        input logic [SAT_MAX_W-1:0] inc,
        input int                   w
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
        return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mul_err_accum.sv
// Exact product, signed error and the four saturating error metrics.
// MUL_ERR_WORST_CAPTURE_EN adds the operands of the first worst-error pair.
module mul_err_accum
    import mul_err_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    valid,
    input  logic [W-1:0]            a,
    input  logic [W-1:0]            b,
    input  logic [2*W-1:0]          prod,
    output logic [cnt_width(W)-1:0] err_cnt,
    output logic [2*W-1:0]          err_max,
    output logic [ACC_W-1:0]        err_sae,
    output logic [ACC_W-1:0]        err_sse
`ifdef MUL_ERR_WORST_CAPTURE_EN
    ,
    output logic [W-1:0]            worst_a,
    output logic [W-1:0]            worst_b
`endif
);

    localparam int PW = 2 * W;
    localparam int CW = cnt_width(W);

    logic [PW-1:0]        exact;
    logic [PW:0]          err;
    logic [PW:0]          err_neg;
    logic [PW-1:0]        abs_err;
    logic [2*PW-1:0]      sq_err;
    logic [SAT_MAX_W-1:0] sae_next;
    logic [SAT_MAX_W-1:0] sse_next;

    // err spans 2W+1 signed bits, so its magnitude always fits in 2W bits.
    always_comb begin
        exact    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        err      = {1'b0, prod} - {1'b0, exact};
        err_neg  = -err;
        abs_err  = err[PW] ? err_neg[PW-1:0] : err[PW-1:0];
        sq_err   = {{PW{1'b0}}, abs_err} * {{PW{1'b0}}, abs_err};
        sae_next = sat_add(SAT_MAX_W'(err_sae), SAT_MAX_W'(abs_err), ACC_W);
        sse_next = sat_add(SAT_MAX_W'(err_sse), SAT_MAX_W'(sq_err), ACC_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_max <= '0;
            err_sae <= '0;
            err_sse <= '0;
`ifdef MUL_ERR_WORST_CAPTURE_EN
            worst_a <= '0;
            worst_b <= '0;
`endif
        end else if (clear) begin
            err_cnt <= '0;
            err_max <= '0;
            err_sae <= '0;
            err_sse <= '0;
`ifdef MUL_ERR_WORST_CAPTURE_EN
            worst_a <= '0;
            worst_b <= '0;
`endif
        end else if (valid) begin
            if (err != '0) begin
                err_cnt <= err_cnt + CW'(1);
            end
            // Strictly greater, so the first pair reaching the max is kept.
            if (abs_err > err_max) begin
                err_max <= abs_err;
`ifdef MUL_ERR_WORST_CAPTURE_EN
                worst_a <= a;
                worst_b <= b;
`endif
            end
            err_sae <= sae_next[ACC_W-1:0];
            err_sse <= sse_next[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/mul_err_sweep_ctrl.sv
// Exhaustive error sweep of an external WxW approximate multiplier.
// MUL_ERR_WORST_CAPTURE_EN adds worst_a/worst_b outputs.
module mul_err_sweep_ctrl
    import mul_err_pkg::*;
#(
    parameter int W       = 8,
    parameter int MUL_LAT = 0,
    parameter int ACC_W   = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    abort,
    output logic [W-1:0]            mul_a,
    output logic [W-1:0]            mul_b,
    input  logic [2*W-1:0]          mul_p,
    output logic                    busy,
    output logic                    done,
    output logic                    res_valid,
    output logic [cnt_width(W)-1:0] err_cnt,
    output logic [2*W-1:0]          err_max,
    output logic [ACC_W-1:0]        err_sae,
    output logic [ACC_W-1:0]        err_sse
`ifdef MUL_ERR_WORST_CAPTURE_EN
    ,
    output logic [W-1:0]            worst_a,
    output logic [W-1:0]            worst_b
`endif
);

    localparam int PW = 2 * W;

    state_e         state;
    logic [PW-1:0]  cnt;
    logic [W-1:0]   pipe_a [0:MUL_LAT];
    logic [W-1:0]   pipe_b [0:MUL_LAT];
    logic [MUL_LAT:0] pipe_v;
    logic           accept;
    logic           issue;
    logic           acc_valid;

    assign accept    = start && !abort && ((state == IDLE) || (state == DONE));
    assign issue     = (state == RUN) && !pause && !abort;
    assign acc_valid = pipe_v[MUL_LAT] && !abort;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign mul_a     = pipe_a[0];
    assign mul_b     = pipe_b[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state     <= RUN;
                            cnt       <= '0;
                            res_valid <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    RUN: begin
                        if (issue) begin
                            cnt <= cnt + PW'(1);
                            if (cnt == '1) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (pipe_v == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            res_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stage 0 is the operand register seen by the multiplier; the rest
    // delay the operands so the exact product lines up with mul_p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                pipe_a[k] <= '0;
                pipe_b[k] <= '0;
            end
        end else if (abort) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= issue;
            if (issue) begin
                pipe_a[0] <= cnt[W-1:0];
                pipe_b[0] <= cnt[PW-1:W];
            end
            for (int k = 1; k <= MUL_LAT; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_a[k] <= pipe_a[k-1];
                pipe_b[k] <= pipe_b[k-1];
            end
        end
    end

    mul_err_accum #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .valid   (acc_valid),
        .a       (pipe_a[MUL_LAT]),
        .b       (pipe_b[MUL_LAT]),
        .prod    (mul_p),
        .err_cnt (err_cnt),
        .err_max (err_max),
        .err_sae (err_sae),
        .err_sse (err_sse)
`ifdef MUL_ERR_WORST_CAPTURE_EN
        ,
        .worst_a (worst_a),
        .worst_b (worst_b)
`endif
    );

endmodule

// File: tb/tb_mul_err_sweep_ctrl.sv
// Self-checking bench: table-driven multiplier model with latency, reference
// error metrics computed by plain loops over all operand pairs.
module tb_mul_err_sweep_ctrl;

    localparam int W        = 3;
    localparam int MUL_LAT  = 2;
    localparam int ACC_W    = 48;
    localparam int PW       = 2 * W;
    localparam int NA       = 1 << W;
    localparam int NP       = 1 << PW;
    localparam int BASE_LAT = NP + MUL_LAT + 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            pause;
    logic            abort;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic [PW-1:0]   mul_p;
    logic            busy;
    logic            done;
    logic            res_valid;
    logic [PW:0]     err_cnt;
    logic [PW-1:0]   err_max;
    logic [ACC_W-1:0] err_sae;
    logic [ACC_W-1:0] err_sse;
`ifdef MUL_ERR_WORST_CAPTURE_EN
    logic [W-1:0]    worst_a;
    logic [W-1:0]    worst_b;
`endif

    int total = 0;
    int bad   = 0;

    int prod_tab [0:NP-1];
    logic [W-1:0] dly_a [1:MUL_LAT];
    logic [W-1:0] dly_b [1:MUL_LAT];

    longint exp_cnt, exp_max, exp_sae, exp_sse, exp_wa, exp_wb;

    always #5 clk = ~clk;

    mul_err_sweep_ctrl #(
        .W       (W),
        .MUL_LAT (MUL_LAT),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .err_cnt   (err_cnt),
        .err_max   (err_max),
        .err_sae   (err_sae),
        .err_sse   (err_sse)
`ifdef MUL_ERR_WORST_CAPTURE_EN
        ,
        .worst_a   (worst_a),
        .worst_b   (worst_b)
`endif
    );

    // Multiplier stand-in: lookup table behind a MUL_LAT-cycle delay line.
    always @(posedge clk) begin
        dly_a[1] <= mul_a;
        dly_b[1] <= mul_b;
        for (int k = 2; k <= MUL_LAT; k++) begin
            dly_a[k] <= dly_a[k-1];
            dly_b[k] <= dly_b[k-1];
        end
    end

    assign mul_p = PW'(prod_tab[{dly_b[MUL_LAT], dly_a[MUL_LAT]}]);

    task automatic check_output(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: exact, 1: tied to zero, 2: random mix of exact and garbage
    task automatic fill_table(input int mode);
        for (int i = 0; i < NP; i++) begin
            int a;
            int b;
            a = i % NA;
            b = i / NA;
            case (mode)
                0: prod_tab[i] = a * b;
                1: prod_tab[i] = 0;
                default: prod_tab[i] = ($urandom_range(0, 1) == 0) ? a * b
                                                                     : int'($urandom_range(0, NP - 1));
            endcase
        end
    endtask

    task automatic compute_expected();
        exp_cnt = 0; exp_max = 0; exp_sae = 0; exp_sse = 0; exp_wa = 0; exp_wb = 0;
        for (int b = 0; b < NA; b++) begin
            for (int a = 0; a < NA; a++) begin
                longint e;
                longint ae;
                e  = longint'(prod_tab[b * NA + a]) - longint'(a * b);
                ae = (e < 0) ? -e : e;
                if (e != 0) exp_cnt++;
                if (ae > exp_max) begin
                    exp_max = ae;
                    exp_wa  = a;
                    exp_wb  = b;
                end
                exp_sae += ae;
                exp_sse += ae * ae;
            end
        end
    endtask

    task automatic check_results(input string tag);
        check_output({tag, ".err_cnt"}, longint'(err_cnt), exp_cnt);
        check_output({tag, ".err_max"}, longint'(err_max), exp_max);
        check_output({tag, ".err_sae"}, longint'(err_sae), exp_sae);
        check_output({tag, ".err_sse"}, longint'(err_sse), exp_sse);
        check_output({tag, ".res_valid"}, longint'(res_valid), 1);
        check_output({tag, ".busy"}, longint'(busy), 0);
`ifdef MUL_ERR_WORST_CAPTURE_EN
        check_output({tag, ".worst_a"}, longint'(worst_a), exp_wa);
        check_output({tag, ".worst_b"}, longint'(worst_b), exp_wb);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".busy"}, longint'(busy), 0);
        check_output({tag, ".done"}, longint'(done), 0);
        check_output({tag, ".res_valid"}, longint'(res_valid), 0);
        check_output({tag, ".mul_a"}, longint'(mul_a), 0);
        check_output({tag, ".mul_b"}, longint'(mul_b), 0);
        check_output({tag, ".err_cnt"}, longint'(err_cnt), 0);
        check_output({tag, ".err_max"}, longint'(err_max), 0);
        check_output({tag, ".err_sae"}, longint'(err_sae), 0);
        check_output({tag, ".err_sse"}, longint'(err_sse), 0);
`ifdef MUL_ERR_WORST_CAPTURE_EN
        check_output({tag, ".worst_a"}, longint'(worst_a), 0);
        check_output({tag, ".worst_b"}, longint'(worst_b), 0);
`endif
    endtask

    // Start a sweep; cycles counts edges from the accepting edge to the
    // edge that raises done (-1 if it never comes within the budget).
    task automatic apply_stimulus(input int pause_at, input int pause_len, input int restart_at,
                                  output int cycles, output int pulses);
        int cyc;
        bit seen;
        cycles = -1;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 1000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            pause = (cyc >= pause_at) && (cyc < pause_at + pause_len);
            start = (cyc == restart_at);
            if (done) begin
                seen   = 1'b1;
                cycles = cyc;
                pulses++;
            end
        end
        pause = 1'b0;
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        int cycles;
        int pulses;

        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        fill_table(0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        pause = 1'b1;
        repeat (3) @(negedge clk);
        check_output("idle_pause.busy", longint'(busy), 0);
        pause = 1'b0;

        $display("[TB] exact multiplier sweep");
        fill_table(0);
        compute_expected();
        apply_stimulus(1000, 0, -1, cycles, pulses);
        check_output("exact.latency", cycles, BASE_LAT);
        check_output("exact.pulses", pulses, 1);
        check_results("exact");

        $display("[TB] tied-zero sweep with start pulsed mid-run");
        fill_table(1);
        compute_expected();
        apply_stimulus(1000, 0, 30, cycles, pulses);
        check_output("zero.latency", cycles, BASE_LAT);
        check_output("zero.pulses", pulses, 1);
        check_results("zero");

        $display("[TB] random table sweep with 5-cycle pause");
        fill_table(2);
        compute_expected();
        apply_stimulus(10, 5, -1, cycles, pulses);
        check_output("pause.latency", cycles, BASE_LAT + 5);
        check_output("pause.pulses", pulses, 1);
        check_results("pause");

        $display("[TB] abort mid-run then restart");
        fill_table(2);
        compute_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_output("abort.busy", longint'(busy), 0);
        check_output("abort.res_valid", longint'(res_valid), 0);
        pulses = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_output("abort.pulses", pulses, 0);
        check_output("abort.idle_busy", longint'(busy), 0);
        apply_stimulus(1000, 0, -1, cycles, pulses);
        check_output("restart.latency", cycles, BASE_LAT);
        check_output("restart.pulses", pulses, 1);
        check_results("restart");

        $display("[TB] reset asserted during drain");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (NP + 1) @(negedge clk);
        check_output("drain.busy", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("drain_reset");
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_output("drain_reset.pulses", pulses, 0);
        check_output("drain_reset.busy", longint'(busy), 0);
        check_output("drain_reset.res_valid", longint'(res_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_err_sweep_ctrl.md
Name: mul_err_sweep_ctrl

Overview:
- Sequences an exhaustive error-characterisation sweep of one external unsigned WxW approximate multiplier (DUT multiplier), e.g. DT_8_8_12_approx_fa_2_127.
- Issues every operand pair once, computes the exact product internally and accumulates four error metrics: error count, max |err|, sum |err|, sum err².
- Sits between a host/testbench control interface and the multiplier instance. Provides start/pause/abort control and held results.

Parameters:
- W, 8, operand width; product width 2W, pair count 2^(2W).
- MUL_LAT, 0, cycles from operands valid on mul_a/mul_b to product valid on mul_p; range 0..3.
- ACC_W, 48, width of sum accumulators; must be ≥ 6W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; honoured only in IDLE or DONE.
- pause  in  1  while high, no new pair is issued.
- abort  in  1  terminate sweep, return to IDLE.
- mul_a  out  W  operand A to multiplier (registered).
- mul_b  out  W  operand B to multiplier (registered).
- mul_p  in  2W  product from multiplier.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when results become final.
- res_valid  out  1  results final; cleared by start, abort or reset.
- err_cnt  out  2W+1  number of pairs with mul_p != exact.
- err_max  out  2W  max |mul_p − exact|.
- err_sae  out  ACC_W  sum of |err|.
- err_sse  out  ACC_W  sum of err².

Behaviour:
- Reset: state IDLE; all outputs 0; pair counter 0; valid pipeline cleared.
- FSM states:
  - IDLE: start → RUN; clear accumulators, counter and res_valid.
  - RUN: each cycle with pause=0, register mul_a=cnt[W-1:0], mul_b=cnt[2W-1:W], push issue-valid (with a,b) into a MUL_LAT-deep pipe, then increment cnt. After issuing cnt = 2^(2W)−1 → DRAIN.
  - DRAIN: wait until the pipe is empty, then → DONE.
  - DONE: done=1 for exactly one cycle, res_valid=1, then → IDLE. Results held until the next start, abort or reset.
- Sampling: a pair issued (registered) in cycle t has mul_p sampled at end of cycle t+MUL_LAT. Exact product a*b is computed from the delayed copy of a,b.
- Error arithmetic:
  - err = mul_p − exact as (2W+1)-bit signed; |err| < 2^(2W).
  - err_cnt increments when err != 0.
  - err_max = max(err_max, |err|).
  - sae += |err|; sse += |err|² (4W-bit square, zero-extended).
  - Accumulators saturate at all-ones, never wrap.
- pause: stops issuing only. In-flight products are still accumulated; mul_a/mul_b hold their last value. Pause in IDLE/DONE has no effect.
- abort: highest priority, any state → IDLE next cycle. Pipe flushed; res_valid=0; done not pulsed; accumulators retain partial values.
- start while busy: ignored. Simultaneous start+abort: abort wins.
- Latency: start accepted at edge 0; done pulses 2^(2W)+MUL_LAT+2 cycles later with no pause.
- Async reset mid-sweep: immediate return to reset values; no partial result is flagged valid.

Optional Feature:
- MUL_ERR_WORST_CAPTURE_EN defined:
  - Extra outputs worst_a and worst_b (W each) hold the operands of the first pair that reached the current err_max (strictly-greater update only).
  - Both are cleared on start and reset.
- Undefined: ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package mul_err_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - a function computing the err_cnt width from W;
  - a saturating-add function.
- One sub-module, mul_err_accum: the exact product, error computation and the four saturating accumulators (plus optional worst capture).
- The FSM, counter and valid pipe stay in the top.

Test Plan:
- W=8, MUL_LAT=0, exact multiplier model → err_cnt=0, err_max=0, sae=0, sse=0; done 65538 cycles after start.
- W=2, MUL_LAT=1, mul_p tied to 0 → err_cnt=9, err_max=9, sae=36, sse=196; done pulse exactly once.
- W=2, MUL_LAT=2, pause held high for 5 cycles mid-RUN → identical results to the unpaused run; done delayed by exactly 5 cycles.
- W=8, reference approx DUT, abort at cycle 1000 → IDLE next cycle, res_valid=0, no done. Restart then completes with err_max equal to the golden C-model value.
- start pulsed during RUN, and rst_n asserted mid-DRAIN → start ignored (cycle count unchanged); after reset all outputs are 0 and state is IDLE.
- With MUL_ERR_WORST_CAPTURE_EN, W=2, mul_p=0 → worst_a=3, worst_b=3.
